k423_imem_arb: RTL and testbench
================================

Name: k423_imem_arb

Overview:
- Shares the single instruction/data memory port between the IF fetch requester (read-only) and the LSU requester (read/write).
- Tracks in-flight requests in an in-order owner queue and routes each memory response back to its issuer.
- Drops stale IF responses after a front-end flush, and uses an anti-starvation counter so IF is not locked out by LSU priority.
- Sits between k423_if_fetch / the LSU and the memory bus.

Parameters:
- ADDR_W, 32, request address width (matches `CORE_ADDR_W)
- DATA_W, 32, write/read data width (matches `CORE_XLEN / `CORE_FETCH_W)
- OUTSTD_DEPTH, 4, maximum in-flight requests; power of two, ≥2
- STARVE_MAX, 4, number of consecutive blocked IF cycles before IF is forced to win

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- if_flush_i  in  1  front-end redirect; discard all older outstanding IF responses
- if_req_vld_i  in  1  IF request valid
- if_req_addr_i  in  ADDR_W  IF fetch address
- if_req_rdy_o  out  1  IF request accepted
- if_rsp_vld_o  out  1  IF response valid
- if_rsp_rdata_o  out  DATA_W  IF response data
- lsu_req_vld_i  in  1  LSU request valid
- lsu_req_wen_i  in  1  LSU write enable
- lsu_req_addr_i  in  ADDR_W  LSU address
- lsu_req_wdata_i  in  DATA_W  LSU write data
- lsu_req_rdy_o  out  1  LSU request accepted
- lsu_rsp_vld_o  out  1  LSU response valid
- lsu_rsp_rdata_o  out  DATA_W  LSU response data
- mem_req_vld_o  out  1  downstream request valid
- mem_req_wen_o  out  1  downstream write enable
- mem_req_addr_o  out  ADDR_W  downstream address
- mem_req_wdata_o  out  DATA_W  downstream write data
- mem_req_rdy_i  in  1  downstream ready
- mem_rsp_vld_i  in  1  downstream response valid
- mem_rsp_rdata_i  in  DATA_W  downstream response data
- outstd_cnt_o  out  clog2(OUTSTD_DEPTH)+1  current queue occupancy
- arb_err_o  out  1  sticky protocol error flag

Behaviour:
- Memory contract: every accepted request, reads and writes alike, produces exactly one mem_rsp_vld_i, in order, at least 1 cycle after acceptance.
- Request path is combinational; zero added latency.
- Grant:
  - LSU wins by default.
  - IF wins when LSU is idle, or when starve_cnt == STARVE_MAX.
- mem_req_vld_o = (if_req_vld_i | lsu_req_vld_i) & ~full.
- mem_req_* fields are muxed from the winner. IF always drives wen=0 and wdata=0.
- The winner's rdy = mem_req_rdy_i & ~full. The loser's rdy = 0.
- Handshake = mem_req_vld_o & mem_req_rdy_i. On handshake, push the entry {owner, discard=0} into the owner queue.
- Full blocks the push even if a pop happens in the same cycle. There is no bypass; this is a deliberate simplification.
- starve_cnt:
  - Width clog2(STARVE_MAX+1).
  - Increments (saturating at STARVE_MAX) on each cycle if_req_vld_i=1 and IF is not handshaking.
  - Clears on an IF handshake or when if_req_vld_i=0.
- Response routing:
  - On mem_rsp_vld_i with a non-empty queue, pop the head.
  - Assert the owner's rsp_vld for that cycle unless the entry's discard bit is set.
  - rdata is broadcast to both rsp_rdata outputs.
- Flush:
  - if_flush_i sets discard on every queued IF entry that exists at the start of the cycle.
  - An IF response popping in the flush cycle is also suppressed (combinational).
  - An IF request accepted in the flush cycle is NOT discarded, because it carries the redirect target.
  - LSU entries are never discarded.
- Protocol error: arb_err_o is set when mem_rsp_vld_i arrives with the queue empty. The response is ignored, and arb_err_o stays high until reset.
- Simultaneous push and pop on a non-full queue: occupancy is unchanged, and pointers wrap modulo OUTSTD_DEPTH.
- Reset (async, rst_i=1):
  - Queue is empty and pointers are 0.
  - starve_cnt=0, arb_err_o=0, outstd_cnt_o=0.
  - While in reset: mem_req_vld_o, if/lsu rsp_vld and both rdy outputs are forced to 0.
  - In-flight responses arriving after reset release count as protocol errors.

Decomposition:
- k423_pkg / k423_defines.svh carries:
  - owner enum (OWN_IF=1'b0, OWN_LSU=1'b1)
  - arb queue entry struct {owner, discard}
  - default OUTSTD_DEPTH and STARVE_MAX constants
- One sub-module: k423_arb_owner_fifo. It is the parameterized in-order queue and additionally supports a "mark all IF entries discard" operation.

Test Plan:
- IF-only reads to 0x100, 0x104 with mem_req_rdy_i=1 and 2-cycle response latency -> both accepted back to back. if_rsp_vld_o fires twice in order with the matching rdata. lsu_rsp_vld_o stays 0.
- Both requesters valid every cycle, 4 LSU reads then IF -> LSU wins 4 cycles (starve_cnt 1..4). The 5th cycle grants IF. Counter returns to 0.
- Accept 3 IF requests, pulse if_flush_i with a new IF request to 0x200 in the same cycle -> the 3 old responses are suppressed and only the 0x200 response is delivered. outstd_cnt_o goes 4→0.
- Hold mem_rsp_vld_i=0 after 4 handshakes -> full; both rdy=0 and mem_req_vld_o=0. A pop plus a push attempt in the same cycle leaves 3 entries.
- Interleave an LSU write to 0x80, an IF read and an LSU read -> responses route LSU, IF, LSU. The write ack pulses lsu_rsp_vld_o once.
- Send mem_rsp_vld_i with an empty queue -> arb_err_o=1 and stays 1. Assert rst_i mid-traffic -> all state clears asynchronously and arb_err_o=0.

Source files
------------

// File: rtl/k423_pkg.sv
// Shared types and defaults for the k423 instruction/data memory arbiter.
package k423_pkg;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    typedef struct packed {
        owner_e owner;
        logic   discard;
    } arb_entry_t;

    localparam int unsigned DEF_OUTSTD_DEPTH = 4;
    localparam int unsigned DEF_STARVE_MAX   = 4;

endpackage

// File: rtl/k423_arb_owner_fifo.sv
// In-order owner queue for outstanding memory requests, with a bulk
// "discard every queued IF entry" operation used on front-end flush.
module k423_arb_owner_fifo
    import k423_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_OUTSTD_DEPTH
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push,
    input  arb_entry_t                 push_data,
    input  logic                       pop,
    input  logic                       flush_if,
    output arb_entry_t                 head,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    arb_entry_t          mem_q [DEPTH];
    logic [AW-1:0]       wptr_q;
    logic [AW-1:0]       rptr_q;
    logic [CW-1:0]       cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            // Marking empty slots is harmless; a later push overwrites them.
            if (flush_if) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (mem_q[i].owner == OWN_IF) begin
                        mem_q[i].discard <= 1'b1;
                    end
                end
            end
            if (push) begin
                mem_q[wptr_q] <= push_data;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign head  = mem_q[rptr_q];
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(DEPTH));
    assign cnt   = cnt_q;

endmodule

// File: rtl/k423_imem_arb.sv
// Shares one memory port between IF fetch and the LSU, routing in-order
// responses back to their issuer and dropping stale IF responses on flush.
module k423_imem_arb
    import k423_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned OUTSTD_DEPTH = DEF_OUTSTD_DEPTH,
    parameter int unsigned STARVE_MAX   = DEF_STARVE_MAX
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            if_flush_i,
    input  logic                            if_req_vld_i,
    input  logic [ADDR_W-1:0]               if_req_addr_i,
    output logic                            if_req_rdy_o,
    output logic                            if_rsp_vld_o,
    output logic [DATA_W-1:0]               if_rsp_rdata_o,
    input  logic                            lsu_req_vld_i,
    input  logic                            lsu_req_wen_i,
    input  logic [ADDR_W-1:0]               lsu_req_addr_i,
    input  logic [DATA_W-1:0]               lsu_req_wdata_i,
    output logic                            lsu_req_rdy_o,
    output logic                            lsu_rsp_vld_o,
    output logic [DATA_W-1:0]               lsu_rsp_rdata_o,
    output logic                            mem_req_vld_o,
    output logic                            mem_req_wen_o,
    output logic [ADDR_W-1:0]               mem_req_addr_o,
    output logic [DATA_W-1:0]               mem_req_wdata_o,
    input  logic                            mem_req_rdy_i,
    input  logic                            mem_rsp_vld_i,
    input  logic [DATA_W-1:0]               mem_rsp_rdata_i,
    output logic [$clog2(OUTSTD_DEPTH):0]   outstd_cnt_o,
    output logic                            arb_err_o
);

    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    logic              full;
    logic              empty;
    logic              if_wins;
    logic              handshake;
    logic              pop;
    logic              deliver;
    arb_entry_t        head;
    arb_entry_t        push_entry;
    logic [SW-1:0]     starve_q;
    logic              arb_err_q;

    assign if_wins   = if_req_vld_i & (~lsu_req_vld_i | (starve_q == SW'(STARVE_MAX)));
    assign handshake = mem_req_vld_o & mem_req_rdy_i;

    always_comb begin
        mem_req_vld_o   = ~rst_i & (if_req_vld_i | lsu_req_vld_i) & ~full;
        if_req_rdy_o    = ~rst_i & if_wins & mem_req_rdy_i & ~full;
        lsu_req_rdy_o   = ~rst_i & ~if_wins & mem_req_rdy_i & ~full;
        if (if_wins) begin
            mem_req_wen_o   = 1'b0;
            mem_req_addr_o  = if_req_addr_i;
            mem_req_wdata_o = '0;
        end else begin
            mem_req_wen_o   = lsu_req_wen_i;
            mem_req_addr_o  = lsu_req_addr_i;
            mem_req_wdata_o = lsu_req_wdata_i;
        end
        push_entry.owner   = if_wins ? OWN_IF : OWN_LSU;
        push_entry.discard = 1'b0;
    end

    // An IF response popping during the flush cycle is already stale.
    assign pop     = mem_rsp_vld_i & ~empty;
    assign deliver = pop & ~head.discard & ~((head.owner == OWN_IF) & if_flush_i);

    assign if_rsp_vld_o    = ~rst_i & deliver & (head.owner == OWN_IF);
    assign lsu_rsp_vld_o   = ~rst_i & deliver & (head.owner == OWN_LSU);
    assign if_rsp_rdata_o  = mem_rsp_rdata_i;
    assign lsu_rsp_rdata_o = mem_rsp_rdata_i;
    assign arb_err_o       = arb_err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            starve_q  <= '0;
            arb_err_q <= 1'b0;
        end else begin
            if (!if_req_vld_i || (handshake && if_wins)) begin
                starve_q <= '0;
            end else if (starve_q != SW'(STARVE_MAX)) begin
                starve_q <= starve_q + 1'b1;
            end
            if (mem_rsp_vld_i && empty) begin
                arb_err_q <= 1'b1;
            end
        end
    end

    k423_arb_owner_fifo #(
        .DEPTH (OUTSTD_DEPTH)
    ) u_owner_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (handshake),
        .push_data (push_entry),
        .pop       (pop),
        .flush_if  (if_flush_i),
        .head      (head),
        .empty     (empty),
        .full      (full),
        .cnt       (outstd_cnt_o)
    );

endmodule

// File: tb/tb_k423_imem_arb.sv
// Self-checking bench for k423_imem_arb: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_k423_imem_arb;

    localparam int unsigned ADDR_W       = 32;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned OUTSTD_DEPTH = 4;
    localparam int unsigned STARVE_MAX   = 4;

    logic                          clk_i = 1'b0;
    logic                          rst_i;
    logic                          if_flush_i;
    logic                          if_req_vld_i;
    logic [ADDR_W-1:0]             if_req_addr_i;
    logic                          if_req_rdy_o;
    logic                          if_rsp_vld_o;
    logic [DATA_W-1:0]             if_rsp_rdata_o;
    logic                          lsu_req_vld_i;
    logic                          lsu_req_wen_i;
    logic [ADDR_W-1:0]             lsu_req_addr_i;
    logic [DATA_W-1:0]             lsu_req_wdata_i;
    logic                          lsu_req_rdy_o;
    logic                          lsu_rsp_vld_o;
    logic [DATA_W-1:0]             lsu_rsp_rdata_o;
    logic                          mem_req_vld_o;
    logic                          mem_req_wen_o;
    logic [ADDR_W-1:0]             mem_req_addr_o;
    logic [DATA_W-1:0]             mem_req_wdata_o;
    logic                          mem_req_rdy_i;
    logic                          mem_rsp_vld_i;
    logic [DATA_W-1:0]             mem_rsp_rdata_i;
    logic [$clog2(OUTSTD_DEPTH):0] outstd_cnt_o;
    logic                          arb_err_o;

    int n_tests = 0;
    int n_fails = 0;

    // Reference model: owner queue (0 = IF, 1 = LSU) with discard flags.
    bit own_q  [$];
    bit disc_q [$];
    int starve_m = 0;
    bit err_m    = 0;
    int if_rsp_seen = 0;

    always #5 clk_i = ~clk_i;

    k423_imem_arb #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .OUTSTD_DEPTH (OUTSTD_DEPTH),
        .STARVE_MAX   (STARVE_MAX)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .if_flush_i      (if_flush_i),
        .if_req_vld_i    (if_req_vld_i),
        .if_req_addr_i   (if_req_addr_i),
        .if_req_rdy_o    (if_req_rdy_o),
        .if_rsp_vld_o    (if_rsp_vld_o),
        .if_rsp_rdata_o  (if_rsp_rdata_o),
        .lsu_req_vld_i   (lsu_req_vld_i),
        .lsu_req_wen_i   (lsu_req_wen_i),
        .lsu_req_addr_i  (lsu_req_addr_i),
        .lsu_req_wdata_i (lsu_req_wdata_i),
        .lsu_req_rdy_o   (lsu_req_rdy_o),
        .lsu_rsp_vld_o   (lsu_rsp_vld_o),
        .lsu_rsp_rdata_o (lsu_rsp_rdata_o),
        .mem_req_vld_o   (mem_req_vld_o),
        .mem_req_wen_o   (mem_req_wen_o),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_req_wdata_o (mem_req_wdata_o),
        .mem_req_rdy_i   (mem_req_rdy_i),
        .mem_rsp_vld_i   (mem_rsp_vld_i),
        .mem_rsp_rdata_i (mem_rsp_rdata_i),
        .outstd_cnt_o    (outstd_cnt_o),
        .arb_err_o       (arb_err_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        if_flush_i      = 1'b0;
        if_req_vld_i    = 1'b0;
        if_req_addr_i   = '0;
        lsu_req_vld_i   = 1'b0;
        lsu_req_wen_i   = 1'b0;
        lsu_req_addr_i  = '0;
        lsu_req_wdata_i = '0;
        mem_req_rdy_i   = 1'b1;
        mem_rsp_vld_i   = 1'b0;
        mem_rsp_rdata_i = '0;
    endtask

    // Check all outputs against the model at the falling edge, then advance the model.
    task automatic step();
        bit full_m, win, mvld, hs, o, d, exp_ifr, exp_lsr;
        @(negedge clk_i);
        if (rst_i) begin
            chk("rst_mem_req_vld", 64'(mem_req_vld_o), 64'd0);
            chk("rst_if_rdy", 64'(if_req_rdy_o), 64'd0);
            chk("rst_lsu_rdy", 64'(lsu_req_rdy_o), 64'd0);
            chk("rst_if_rsp", 64'(if_rsp_vld_o), 64'd0);
            chk("rst_lsu_rsp", 64'(lsu_rsp_vld_o), 64'd0);
            chk("rst_cnt", 64'(outstd_cnt_o), 64'd0);
            chk("rst_err", 64'(arb_err_o), 64'd0);
            own_q.delete();
            disc_q.delete();
            starve_m = 0;
            err_m    = 1'b0;
        end else begin
            full_m = (own_q.size() == OUTSTD_DEPTH);
            win    = if_req_vld_i && (!lsu_req_vld_i || starve_m == STARVE_MAX);
            mvld   = (if_req_vld_i || lsu_req_vld_i) && !full_m;
            chk("mem_req_vld", 64'(mem_req_vld_o), 64'(mvld));
            chk("if_req_rdy", 64'(if_req_rdy_o), 64'(win && mem_req_rdy_i && !full_m));
            chk("lsu_req_rdy", 64'(lsu_req_rdy_o), 64'(!win && mem_req_rdy_i && !full_m));
            if (mvld) begin
                chk("mem_req_addr", 64'(mem_req_addr_o), win ? 64'(if_req_addr_i) : 64'(lsu_req_addr_i));
                chk("mem_req_wen", 64'(mem_req_wen_o), win ? 64'd0 : 64'(lsu_req_wen_i));
                chk("mem_req_wdata", 64'(mem_req_wdata_o), win ? 64'd0 : 64'(lsu_req_wdata_i));
            end
            exp_ifr = 1'b0;
            exp_lsr = 1'b0;
            if (mem_rsp_vld_i && own_q.size() > 0) begin
                o = own_q[0];
                d = disc_q[0] || (!o && if_flush_i);
                exp_ifr = !o && !d;
                exp_lsr = o;
            end
            chk("if_rsp_vld", 64'(if_rsp_vld_o), 64'(exp_ifr));
            chk("lsu_rsp_vld", 64'(lsu_rsp_vld_o), 64'(exp_lsr));
            if (exp_ifr) chk("if_rsp_rdata", 64'(if_rsp_rdata_o), 64'(mem_rsp_rdata_i));
            if (exp_lsr) chk("lsu_rsp_rdata", 64'(lsu_rsp_rdata_o), 64'(mem_rsp_rdata_i));
            if (if_rsp_vld_o) if_rsp_seen++;
            chk("outstd_cnt", 64'(outstd_cnt_o), 64'(own_q.size()));
            chk("arb_err", 64'(arb_err_o), 64'(err_m));

            hs = mvld && mem_req_rdy_i;
            if (mem_rsp_vld_i) begin
                if (own_q.size() > 0) begin
                    void'(own_q.pop_front());
                    void'(disc_q.pop_front());
                end else begin
                    err_m = 1'b1;
                end
            end
            if (if_flush_i) begin
                foreach (own_q[i]) if (!own_q[i]) disc_q[i] = 1'b1;
            end
            if (hs) begin
                own_q.push_back(!win);
                disc_q.push_back(1'b0);
            end
            if (!if_req_vld_i || (hs && win)) starve_m = 0;
            else if (starve_m < STARVE_MAX) starve_m++;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic drain();
        idle();
        for (int k = 0; k < 2 * OUTSTD_DEPTH && own_q.size() > 0; k++) begin
            mem_rsp_vld_i   = 1'b1;
            mem_rsp_rdata_i = $urandom;
            step();
        end
        mem_rsp_vld_i = 1'b0;
    endtask

    initial begin
        idle();
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
        step();

        // IF-only reads, 2-cycle response latency.
        if_req_vld_i = 1'b1; if_req_addr_i = 32'h100; step();
        if_req_addr_i = 32'h104; step();
        if_req_vld_i = 1'b0;
        mem_rsp_vld_i = 1'b1; mem_rsp_rdata_i = 32'hAAAA_0100; step();
        mem_rsp_rdata_i = 32'hBBBB_0104; step();
        mem_rsp_vld_i = 1'b0; step();

        // Both requesters busy: LSU four times, then IF forced through.
        if_req_vld_i = 1'b1; if_req_addr_i = 32'h300;
        lsu_req_vld_i = 1'b1; lsu_req_addr_i = 32'h40;
        for (int c = 0; c < 6; c++) begin
            mem_rsp_vld_i   = (c > 0);
            mem_rsp_rdata_i = 32'h5000 + 32'(c);
            #1;
            if (c < 4 || c == 5) chk("starve_lsu_rdy", 64'(lsu_req_rdy_o), 64'd1);
            else                 chk("starve_if_rdy", 64'(if_req_rdy_o), 64'd1);
            step();
        end
        drain();

        // Flush with a redirect request in the same cycle.
        if_req_vld_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if_req_addr_i = 32'h180 + 32'(4 * c);
            step();
        end
        if_flush_i = 1'b1; if_req_addr_i = 32'h200; step();
        idle();
        #1;
        chk("flush_cnt4", 64'(outstd_cnt_o), 64'd4);
        if_rsp_seen = 0;
        drain();
        chk("flush_one_rsp", 64'(if_rsp_seen), 64'd1);
        chk("flush_cnt0", 64'(outstd_cnt_o), 64'd0);

        // Fill the queue, then pop with a blocked push in the same cycle.
        lsu_req_vld_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            lsu_req_addr_i = 32'h20 + 32'(4 * c);
            step();
        end
        if_req_vld_i = 1'b1;
        #1;
        chk("full_mem_vld", 64'(mem_req_vld_o), 64'd0);
        chk("full_lsu_rdy", 64'(lsu_req_rdy_o), 64'd0);
        chk("full_if_rdy", 64'(if_req_rdy_o), 64'd0);
        mem_rsp_vld_i = 1'b1; mem_rsp_rdata_i = 32'h77; step();
        idle();
        #1;
        chk("full_pop_cnt3", 64'(outstd_cnt_o), 64'd3);
        drain();

        // LSU write, IF read, LSU read, routed in order.
        lsu_req_vld_i = 1'b1; lsu_req_wen_i = 1'b1; lsu_req_addr_i = 32'h80;
        lsu_req_wdata_i = 32'hDEAD_BEEF; step();
        idle(); if_req_vld_i = 1'b1; if_req_addr_i = 32'h108; step();
        idle(); lsu_req_vld_i = 1'b1; lsu_req_addr_i = 32'h84; step();
        drain();

        // Random traffic.
        for (int c = 0; c < 1500; c++) begin
            if_req_vld_i    = 1'($urandom_range(0, 1));
            if_req_addr_i   = $urandom & 32'hFFFF_FFFC;
            lsu_req_vld_i   = 1'($urandom_range(0, 1));
            lsu_req_wen_i   = 1'($urandom_range(0, 1));
            lsu_req_addr_i  = $urandom;
            lsu_req_wdata_i = $urandom;
            mem_req_rdy_i   = ($urandom_range(0, 3) != 0);
            if_flush_i      = ($urandom_range(0, 9) == 0);
            mem_rsp_vld_i   = (own_q.size() > 0) && ($urandom_range(0, 1) == 1);
            mem_rsp_rdata_i = $urandom;
            step();
        end
        drain();

        // Response with nothing outstanding sets the sticky error.
        mem_rsp_vld_i = 1'b1; step();
        mem_rsp_vld_i = 1'b0; step(); step();
        #1;
        chk("err_sticky", 64'(arb_err_o), 64'd1);

        // Asynchronous reset mid-traffic.
        if_req_vld_i = 1'b1; if_req_addr_i = 32'h400;
        step(); step();
        #2;
        rst_i = 1'b1;
        #1;
        chk("async_mem_vld", 64'(mem_req_vld_o), 64'd0);
        chk("async_if_rdy", 64'(if_req_rdy_o), 64'd0);
        chk("async_cnt", 64'(outstd_cnt_o), 64'd0);
        chk("async_err", 64'(arb_err_o), 64'd0);
        mem_rsp_vld_i = 1'b1; step();
        rst_i = 1'b0; if_req_vld_i = 1'b0; step();
        mem_rsp_vld_i = 1'b0; step();
        #1;
        chk("post_rst_err", 64'(arb_err_o), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
